cache_mem_bridge: RTL and testbench
===================================

# cache_mem_bridge

Sits directly downstream of the cache controller, between the cache and main memory. Accepts one line transaction at a time: an optional dirty-line write-back followed by a refill, or a write-back alone. Serialises each transaction into single-word accesses on a fixed-latency memory port and returns the refilled line with a one-cycle completion pulse. Owns all main-memory sequencing, so the cache controller only needs to wait for `resp_valid`.

## Interface
- `ADDR_W`, 32: word-address width.
- `DATA_W`, 32: word width.
- `WORDS`, 4: words per line; power of two, ≥2.
- `MEM_LAT`, 2: cycles from `mem_re` to valid `mem_rdata`; ≥1.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in 1: transaction request.
- `req_ready` out 1: high only in IDLE.
- `req_wb` in 1: perform write-back first.
- `req_fill` in 1: perform refill.
- `req_wb_addr` in ADDR_W: victim line address.
- `req_fill_addr` in ADDR_W: refill line address.
- `req_wb_line` in WORDS*DATA_W: victim data; word 0 in the LSBs.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_line` out WORDS*DATA_W: refilled line; word 0 in the LSBs.
- `mem_addr` out ADDR_W: memory word address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_we` out 1: memory write strobe.
- `mem_re` out 1: memory read strobe.
- `mem_rdata` in DATA_W: memory read data.

## Operation
- **Accept:** a transaction is accepted on any edge where `req_valid && req_ready`.
  - `req_wb`, `req_fill`, both addresses and `req_wb_line` are captured at that edge.
  - The low log2(WORDS) bits of both captured addresses are forced to 0.
- **Empty request:** `req_wb == 0 && req_fill == 0` is accepted; the block goes straight to DONE.
- **States:** IDLE, WB, RD_ISSUE, RD_WAIT, DONE.
- **Transitions:**
  - IDLE → WB if `req_wb`; else → RD_ISSUE if `req_fill`; else → DONE.
  - WB: one word per cycle, words 0..WORDS-1 in ascending order. After the last word → RD_ISSUE if `req_fill`, else → DONE.
  - RD_ISSUE: one cycle, `mem_re = 1` → RD_WAIT.
  - RD_WAIT: lasts MEM_LAT cycles. `mem_rdata` is captured into word[idx] at the edge that ends the last wait cycle. Then → RD_ISSUE for the next word, or → DONE after word WORDS-1.
  - DONE: one cycle, `resp_valid = 1` → IDLE.
- **Addressing:** `mem_addr` = captured line address + idx, modulo 2^ADDR_W.
  - The write-back address is used in WB; the refill address is used in RD_ISSUE and RD_WAIT.
  - `mem_addr` = 0 in IDLE and DONE.
- **Write data:** `mem_wdata` = victim word[idx] in WB, else 0.
- **Strobes:** `mem_we` is high only in WB; `mem_re` only in RD_ISSUE. They are never high together.
- **Word index:** `idx` has width log2(WORDS). It resets to 0 on entry to WB and on entry to the first RD_ISSUE.
- **`resp_line`:**
  - Holds its value from the last refill.
  - Updated only by refill captures, so a write-back-only transaction leaves it unchanged.
  - Stable from the DONE cycle until the next refill capture.
- **Ignored input:** `req_valid` while `req_ready == 0` is ignored and not queued.

## Timing
- **Reset values:**
  - All outputs 0 except `req_ready = 1`.
  - `resp_line` = 0; state IDLE; `idx` = 0.
- **Reset mid-transaction:** aborts immediately and leaves no partial strobe. After reset release, no completion pulse is issued for the aborted transaction.
- **Latency (accept edge = E0, cycle numbers counted after E0):**
  - Write-back only: WB occupies cycles 1..WORDS; `resp_valid` in cycle WORDS+1.
  - Refill only: `resp_valid` in cycle WORDS*(MEM_LAT+1)+1.
  - Both: `resp_valid` in cycle WORDS*(MEM_LAT+2)+1.
  - Defaults, both: 17 cycles.
- **Back-to-back:** `req_ready` is low from cycle 1 through DONE. The next accept can happen at the earliest in the cycle after DONE.

## Configuration
- **`CACHE_MEM_BRIDGE_STATS_EN` defined:**
  - Adds outputs `stat_wb_cnt` and `stat_fill_cnt`, each 16 bits, saturating at 0xFFFF.
  - Each counter increments by 1 in the DONE cycle of a transaction with the corresponding flag set.
  - Both reset to 0.
- **Undefined:** the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- **`cache_mem_bridge_pkg`:** state enum `bridge_state_t` (IDLE, WB, RD_ISSUE, RD_WAIT, DONE) and the stats counter width constant `STAT_W = 16`.
- **Sub-module `cache_mem_bridge_linebuf`:** holds the WORDS×DATA_W register array.
  - Load port: whole line.
  - Word-write port: idx, data, enable.
  - Word-read mux: idx.
  - Two instances: victim buffer and fill buffer.
- The FSM, index counter and wait counter live in the top module.

## Test plan
- **Refill only**, defaults, `req_fill_addr = 0x107`:
  - `mem_re` pulses at cycles 1, 4, 7, 10 with addresses 0x104..0x107.
  - Memory returns 0xA0..0xA3 → `resp_valid` at cycle 13, `resp_line = {A3,A2,A1,A0}`.
- **Write-back only**, `req_wb_addr = 0x20`, line {D3,D2,D1,D0}:
  - `mem_we` in cycles 1..4 with addresses 0x20..0x23 and data D0..D3.
  - `resp_valid` at cycle 5; `resp_line` unchanged.
- **Write-back + refill:** all WB writes precede the first `mem_re`; `resp_valid` at cycle 17; `mem_we` and `mem_re` are never both high.
- **Busy request:** `req_valid` held high throughout a transaction → exactly one accept, then a second accept in the cycle after DONE.
- **Reset mid-transaction:** reset asserted at cycle 6 of a refill → all outputs at reset values immediately; no `resp_valid` after release.
- **Address wrap:** `ADDR_W = 4`, `req_fill_addr = 0xE` → addresses 0xC, 0xD, 0xE, 0xF.
- **With `CACHE_MEM_BRIDGE_STATS_EN`:** 3 refills and 2 write-back+refill transactions → `stat_fill_cnt = 5`, `stat_wb_cnt = 2`. Preload a counter to 0xFFFF → it saturates.

Source files
------------

// File: rtl/cache_mem_bridge_pkg.sv
// Shared types and constants for the cache-to-memory line bridge.
package cache_mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD_ISSUE,
    RD_WAIT,
    DONE
  } bridge_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/cache_mem_bridge_linebuf.sv
// One cache line of WORDS x DATA_W registers with whole-line load,
// single-word write and single-word read mux.
module cache_mem_bridge_linebuf #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic [WORDS*DATA_W-1:0] line_i,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  output logic [DATA_W-1:0]       rd_data_o,
  output logic [WORDS*DATA_W-1:0] line_o
);

  logic [WORDS-1:0][DATA_W-1:0] words_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_q <= '0;
    end else if (load_i) begin
      words_q <= line_i;
    end else if (wr_en_i) begin
      words_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = words_q[rd_idx_i];
  assign line_o    = words_q;

endmodule

// File: rtl/cache_mem_bridge.sv
// Serialises a line write-back and/or refill into single-word accesses on a
// fixed-latency memory port. Optional counters: CACHE_MEM_BRIDGE_STATS_EN.
//
// state    | meaning
// IDLE     | ready for a request
// WB       | writing victim word idx
// RD_ISSUE | read strobe for refill word idx
// RD_WAIT  | waiting MEM_LAT cycles for read data of word idx
// DONE     | one-cycle completion pulse
module cache_mem_bridge
  import cache_mem_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WORDS   = 4,
  parameter int MEM_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_wb_i,
  input  logic                    req_fill_i,
  input  logic [ADDR_W-1:0]       req_wb_addr_i,
  input  logic [ADDR_W-1:0]       req_fill_addr_i,
  input  logic [WORDS*DATA_W-1:0] req_wb_line_i,
  output logic                    resp_valid_o,
  output logic [WORDS*DATA_W-1:0] resp_line_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [DATA_W-1:0]       mem_wdata_o,
  output logic                    mem_we_o,
  output logic                    mem_re_o,
`ifdef CACHE_MEM_BRIDGE_STATS_EN
  output logic [STAT_W-1:0]       stat_wb_cnt_o,
  output logic [STAT_W-1:0]       stat_fill_cnt_o,
`endif
  input  logic [DATA_W-1:0]       mem_rdata_i
);

  localparam int IDX_W  = $clog2(WORDS);
  localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(WORDS - 1);

  bridge_state_t     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fill_q;
  logic [ADDR_W-1:0] wb_addr_q, fill_addr_q;
  logic              accept;
  logic              fill_we;
  logic [DATA_W-1:0] vic_word;
  logic [DATA_W-1:0] fill_word_unused;
  logic [WORDS*DATA_W-1:0] vic_line_unused;

  assign accept = req_valid_i && (state_q == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wait_q      <= '0;
      fill_q      <= 1'b0;
      wb_addr_q   <= '0;
      fill_addr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      if (accept) begin
        fill_q      <= req_fill_i;
        wb_addr_q   <= req_wb_addr_i & LINE_MASK;
        fill_addr_q <= req_fill_addr_i & LINE_MASK;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    fill_we      = 1'b0;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_we_o     = 1'b0;
    mem_re_o     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          idx_d = '0;
          if (req_wb_i)        state_d = WB;
          else if (req_fill_i) state_d = RD_ISSUE;
          else                 state_d = DONE;
        end
      end
      WB: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = wb_addr_q + ADDR_W'(idx_q);
        mem_wdata_o = vic_word;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = fill_q ? RD_ISSUE : DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      RD_ISSUE: begin
        mem_re_o   = 1'b1;
        mem_addr_o = fill_addr_q + ADDR_W'(idx_q);
        wait_d     = WAIT_W'(MEM_LAT - 1);
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        mem_addr_o = fill_addr_q + ADDR_W'(idx_q);
        if (wait_q == '0) begin
          fill_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = RD_ISSUE;
          end
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      DONE: begin
        resp_valid_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  cache_mem_bridge_linebuf #(.DATA_W(DATA_W), .WORDS(WORDS), .IDX_W(IDX_W)) u_victim (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept),
    .line_i    (req_wb_line_i),
    .wr_en_i   (1'b0),
    .wr_idx_i  ('0),
    .wr_data_i ('0),
    .rd_idx_i  (idx_q),
    .rd_data_o (vic_word),
    .line_o    (vic_line_unused)
  );

  // resp_line is the fill buffer itself, so it only changes on refill captures
  cache_mem_bridge_linebuf #(.DATA_W(DATA_W), .WORDS(WORDS), .IDX_W(IDX_W)) u_fill (
    .clk       (clk),
    .reset     (reset),
    .load_i    (1'b0),
    .line_i    ('0),
    .wr_en_i   (fill_we),
    .wr_idx_i  (idx_q),
    .wr_data_i (mem_rdata_i),
    .rd_idx_i  (idx_q),
    .rd_data_o (fill_word_unused),
    .line_o    (resp_line_o)
  );

  logic unused_bits;
  assign unused_bits = ^{fill_word_unused, vic_line_unused};

`ifdef CACHE_MEM_BRIDGE_STATS_EN
  logic              wb_q;
  logic [STAT_W-1:0] stat_wb_q, stat_fill_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q        <= 1'b0;
      stat_wb_q   <= '0;
      stat_fill_q <= '0;
    end else begin
      if (accept) wb_q <= req_wb_i;
      if (state_q == DONE) begin
        if (wb_q && (stat_wb_q != '1))     stat_wb_q   <= stat_wb_q + STAT_W'(1);
        if (fill_q && (stat_fill_q != '1)) stat_fill_q <= stat_fill_q + STAT_W'(1);
      end
    end
  end

  assign stat_wb_cnt_o   = stat_wb_q;
  assign stat_fill_cnt_o = stat_fill_q;
`endif

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed self-checking bench for cache_mem_bridge with a fixed-latency
// memory model; a second narrow-address instance covers address wrap.
module tb_cache_mem_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 128;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_wb = 1'b0, req_fill = 1'b0;
  logic [AW-1:0] req_wb_addr = '0, req_fill_addr = '0;
  logic [LW-1:0] req_wb_line = '0;
  logic          req_ready, resp_valid, mem_we, mem_re;
  logic [LW-1:0] resp_line;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          w_req_valid = 1'b0, w_req_ready, w_resp_valid, w_mem_we, w_mem_re;
  logic [3:0]    w_mem_addr;
  logic [LW-1:0] w_resp_line;
  logic [DW-1:0] w_mem_wdata;
  logic [DW-1:0] w_mem_rdata = '0;
  logic [3:0]    w_fill_addr = 4'hE;

`ifdef CACHE_MEM_BRIDGE_STATS_EN
  logic [15:0] stat_wb, stat_fill, w_stat_wb, w_stat_fill;
`endif

  cache_mem_bridge dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_wb_i(req_wb), .req_fill_i(req_fill),
    .req_wb_addr_i(req_wb_addr), .req_fill_addr_i(req_fill_addr),
    .req_wb_line_i(req_wb_line),
    .resp_valid_o(resp_valid), .resp_line_o(resp_line),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_we_o(mem_we), .mem_re_o(mem_re),
`ifdef CACHE_MEM_BRIDGE_STATS_EN
    .stat_wb_cnt_o(stat_wb), .stat_fill_cnt_o(stat_fill),
`endif
    .mem_rdata_i(mem_rdata)
  );

  cache_mem_bridge #(.ADDR_W(4)) dut_w (
    .clk(clk), .reset(reset),
    .req_valid_i(w_req_valid), .req_ready_o(w_req_ready),
    .req_wb_i(1'b0), .req_fill_i(1'b1),
    .req_wb_addr_i(4'h0), .req_fill_addr_i(w_fill_addr),
    .req_wb_line_i({LW{1'b0}}),
    .resp_valid_o(w_resp_valid), .resp_line_o(w_resp_line),
    .mem_addr_o(w_mem_addr), .mem_wdata_o(w_mem_wdata),
    .mem_we_o(w_mem_we), .mem_re_o(w_mem_re),
`ifdef CACHE_MEM_BRIDGE_STATS_EN
    .stat_wb_cnt_o(w_stat_wb), .stat_fill_cnt_o(w_stat_fill),
`endif
    .mem_rdata_i(w_mem_rdata)
  );

  // Memory model: read data valid MEM_LAT=2 cycles after mem_re, else poison
  logic          p0_v = 1'b0, p1_v = 1'b0;
  logic [AW-1:0] p0_a = '0, p1_a = '0;
  logic [DW-1:0] rd_tag = 32'hA0;
  always @(posedge clk) begin
    p0_v <= mem_re;
    p0_a <= mem_addr;
    p1_v <= p0_v;
    p1_a <= p0_a;
  end
  assign mem_rdata = p1_v ? (rd_tag + {30'b0, p1_a[1:0]}) : 32'hDEAD_BEEF;

  int checks = 0;
  int failures = 0;

  logic          l_we[0:31], l_re[0:31], l_rv[0:31], l_rdy[0:31];
  logic [AW-1:0] l_addr[0:31];
  logic [DW-1:0] l_wdata[0:31];

  task automatic issue(input logic wb, input logic fill, input logic [AW-1:0] wa,
                       input logic [AW-1:0] fa, input logic [LW-1:0] line);
    req_wb = wb; req_fill = fill; req_wb_addr = wa; req_fill_addr = fa;
    req_wb_line = line; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic record(input int n);
    for (int i = 1; i <= n; i++) begin
      l_we[i] = mem_we; l_re[i] = mem_re; l_rv[i] = resp_valid; l_rdy[i] = req_ready;
      l_addr[i] = mem_addr; l_wdata[i] = mem_wdata;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
    checks++; if ({mem_we, mem_re} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_we, mem_re}); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    checks++; if (resp_line !== 128'h0) begin failures++; $display("FAIL reset_line got=%h exp=0", resp_line); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_refill;
    logic exp_re, exp_rv, exp_rdy;
    logic [AW-1:0] exp_addr;
    rd_tag = 32'hA0;
    issue(1'b0, 1'b1, 32'h0, 32'h107, '0);
    record(14);
    for (int n = 1; n <= 14; n++) begin
      exp_re = (n == 1) || (n == 4) || (n == 7) || (n == 10);
      exp_rv = (n == 13);
      exp_rdy = (n == 14);
      exp_addr = (n <= 12) ? 32'h104 + 32'((n - 1) / 3) : 32'h0;
      checks++; if (l_re[n] !== exp_re) begin failures++; $display("FAIL refill_re cyc=%0d got=%0b exp=%0b", n, l_re[n], exp_re); end
      checks++; if (l_we[n] !== 1'b0) begin failures++; $display("FAIL refill_we cyc=%0d got=%0b exp=0", n, l_we[n]); end
      checks++; if (l_rv[n] !== exp_rv) begin failures++; $display("FAIL refill_rv cyc=%0d got=%0b exp=%0b", n, l_rv[n], exp_rv); end
      checks++; if (l_rdy[n] !== exp_rdy) begin failures++; $display("FAIL refill_ready cyc=%0d got=%0b exp=%0b", n, l_rdy[n], exp_rdy); end
      checks++; if (l_addr[n] !== exp_addr) begin failures++; $display("FAIL refill_addr cyc=%0d got=%h exp=%h", n, l_addr[n], exp_addr); end
    end
    checks++;
    if (resp_line !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
      failures++; $display("FAIL refill_line got=%h exp=%h", resp_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    end
  endtask

  task automatic test_writeback;
    logic [LW-1:0] line;
    logic exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    line = {32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001, 32'hD0D0_0000};
    issue(1'b1, 1'b0, 32'h23, 32'h999, line);
    record(6);
    for (int n = 1; n <= 6; n++) begin
      exp_we = (n <= 4);
      exp_addr = exp_we ? 32'h20 + 32'(n - 1) : 32'h0;
      exp_wd = exp_we ? 32'hD0D0_0000 + 32'(n - 1) : 32'h0;
      checks++; if (l_we[n] !== exp_we) begin failures++; $display("FAIL wb_we cyc=%0d got=%0b exp=%0b", n, l_we[n], exp_we); end
      checks++; if (l_re[n] !== 1'b0) begin failures++; $display("FAIL wb_re cyc=%0d got=%0b exp=0", n, l_re[n]); end
      checks++; if (l_addr[n] !== exp_addr) begin failures++; $display("FAIL wb_addr cyc=%0d got=%h exp=%h", n, l_addr[n], exp_addr); end
      checks++; if (l_wdata[n] !== exp_wd) begin failures++; $display("FAIL wb_wdata cyc=%0d got=%h exp=%h", n, l_wdata[n], exp_wd); end
      checks++; if (l_rv[n] !== (n == 5)) begin failures++; $display("FAIL wb_rv cyc=%0d got=%0b exp=%0b", n, l_rv[n], n == 5); end
    end
    checks++;
    if (resp_line !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
      failures++; $display("FAIL wb_line_kept got=%h exp=%h", resp_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    end
  endtask

  task automatic test_wb_fill;
    logic [LW-1:0] line;
    logic exp_we, exp_re;
    logic [AW-1:0] exp_addr;
    line = {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000};
    rd_tag = 32'hB0;
    issue(1'b1, 1'b1, 32'h41, 32'h82, line);
    record(18);
    for (int n = 1; n <= 18; n++) begin
      exp_we = (n <= 4);
      exp_re = (n == 5) || (n == 8) || (n == 11) || (n == 14);
      exp_addr = exp_we ? 32'h40 + 32'(n - 1) : ((n <= 16) ? 32'h80 + 32'((n - 5) / 3) : 32'h0);
      checks++; if (l_we[n] !== exp_we) begin failures++; $display("FAIL both_we cyc=%0d got=%0b exp=%0b", n, l_we[n], exp_we); end
      checks++; if (l_re[n] !== exp_re) begin failures++; $display("FAIL both_re cyc=%0d got=%0b exp=%0b", n, l_re[n], exp_re); end
      checks++; if ((l_we[n] && l_re[n]) !== 1'b0) begin failures++; $display("FAIL both_strobes cyc=%0d got=1 exp=0", n); end
      checks++; if (l_addr[n] !== exp_addr) begin failures++; $display("FAIL both_addr cyc=%0d got=%h exp=%h", n, l_addr[n], exp_addr); end
      checks++; if (l_rv[n] !== (n == 17)) begin failures++; $display("FAIL both_rv cyc=%0d got=%0b exp=%0b", n, l_rv[n], n == 17); end
      if (exp_we) begin
        checks++;
        if (l_wdata[n] !== 32'hE000_0000 + 32'(n - 1)) begin
          failures++; $display("FAIL both_wdata cyc=%0d got=%h exp=%h", n, l_wdata[n], 32'hE000_0000 + 32'(n - 1));
        end
      end
    end
    checks++;
    if (resp_line !== {32'hB3, 32'hB2, 32'hB1, 32'hB0}) begin
      failures++; $display("FAIL both_line got=%h exp=%h", resp_line, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    end
  endtask

  task automatic test_back_to_back;
    int acc;
    bit seen;
    rd_tag = 32'hC0;
    req_wb = 1'b0; req_fill = 1'b1; req_fill_addr = 32'h200; req_valid = 1'b1;
    acc = req_ready ? 1 : 0;
    @(posedge clk); #1;
    record(15);
    for (int n = 1; n <= 15; n++) begin
      if (l_rdy[n]) acc++;
      checks++; if (l_rdy[n] !== (n == 14)) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%0b exp=%0b", n, l_rdy[n], n == 14); end
    end
    checks++; if (acc !== 2) begin failures++; $display("FAIL b2b_accepts got=%0d exp=2", acc); end
    checks++; if (l_re[15] !== 1'b1) begin failures++; $display("FAIL b2b_second_issue got=%0b exp=1", l_re[15]); end
    req_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      if (resp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL b2b_second_done got=timeout exp=resp_valid"); end
    checks++;
    if (resp_line !== {32'hC3, 32'hC2, 32'hC1, 32'hC0}) begin
      failures++; $display("FAIL b2b_line got=%h exp=%h", resp_line, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    end
  endtask

  task automatic test_empty;
    issue(1'b0, 1'b0, 32'h0, 32'h0, '0);
    record(2);
    checks++; if (l_rv[1] !== 1'b1) begin failures++; $display("FAIL empty_rv got=%0b exp=1", l_rv[1]); end
    checks++; if ({l_we[1], l_re[1]} !== 2'b00) begin failures++; $display("FAIL empty_strobes got=%b exp=00", {l_we[1], l_re[1]}); end
    checks++; if (l_rdy[2] !== 1'b1) begin failures++; $display("FAIL empty_ready got=%0b exp=1", l_rdy[2]); end
    checks++;
    if (resp_line !== {32'hC3, 32'hC2, 32'hC1, 32'hC0}) begin
      failures++; $display("FAIL empty_line got=%h exp=%h", resp_line, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    end
  endtask

`ifdef CACHE_MEM_BRIDGE_STATS_EN
  task automatic test_stats;
    checks++; if (stat_fill !== 16'd4) begin failures++; $display("FAIL stat_fill got=%0d exp=4", stat_fill); end
    checks++; if (stat_wb !== 16'd2) begin failures++; $display("FAIL stat_wb got=%0d exp=2", stat_wb); end
  endtask
`endif

  task automatic test_reset_mid;
    bit bad_rv, bad_re;
    rd_tag = 32'hF0;
    issue(1'b0, 1'b1, 32'h0, 32'h300, '0);
    record(5);
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0b exp=1", req_ready); end
    checks++; if ({mem_we, mem_re, resp_valid} !== 3'b000) begin failures++; $display("FAIL mid_strobes got=%b exp=000", {mem_we, mem_re, resp_valid}); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL mid_addr got=%h exp=0", mem_addr); end
    checks++; if (resp_line !== 128'h0) begin failures++; $display("FAIL mid_line got=%h exp=0", resp_line); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    record(20);
    bad_rv = 1'b0; bad_re = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (l_rv[n]) bad_rv = 1'b1;
      if (l_re[n]) bad_re = 1'b1;
    end
    checks++; if (bad_rv !== 1'b0) begin failures++; $display("FAIL mid_no_resp got=1 exp=0"); end
    checks++; if (bad_re !== 1'b0) begin failures++; $display("FAIL mid_no_read got=1 exp=0"); end
  endtask

  task automatic test_addr_wrap;
    logic [3:0] seen_a[0:7];
    int cnt;
    int rv_cyc;
    cnt = 0; rv_cyc = -1;
    w_req_valid = 1'b1;
    @(posedge clk); #1;
    w_req_valid = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      if (w_mem_re && cnt < 8) begin seen_a[cnt] = w_mem_addr; cnt++; end
      if (w_resp_valid) rv_cyc = n;
      @(posedge clk); #1;
    end
    checks++; if (cnt !== 4) begin failures++; $display("FAIL wrap_reads got=%0d exp=4", cnt); end
    for (int k = 0; k < 4 && k < cnt; k++) begin
      checks++;
      if (seen_a[k] !== 4'hC + 4'(k)) begin failures++; $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, seen_a[k], 4'hC + 4'(k)); end
    end
    checks++; if (rv_cyc !== 13) begin failures++; $display("FAIL wrap_rv_cycle got=%0d exp=13", rv_cyc); end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_writeback();
    test_wb_fill();
    test_back_to_back();
    test_empty();
`ifdef CACHE_MEM_BRIDGE_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    test_addr_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
